// File: rtl/bscan_bridge_queue.sv
// bscan_bridge_queue: host <-> BSCAN bridge with DEPTH-entry TX and RX FIFOs,
// wrapping transfer counters and a sticky protocol-error flag.
// Optional feature: define BSCAN_BRIDGE_LOOPBACK_EN to add the `loopback`
// port, which routes the TX FIFO head straight into the RX FIFO.
module bscan_bridge_queue #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             say_ENA,
   input  logic [WIDTH-1:0] say_v,
   output logic             say_RDY,
   output logic             tobscan_enq_ENA,
   output logic [WIDTH-1:0] tobscan_enq_v,
   input  logic             tobscan_enq_RDY,
   input  logic             frombscan_enq_ENA,
   input  logic [WIDTH-1:0] frombscan_enq_v,
   output logic             frombscan_enq_RDY,
   output logic             heard_ENA,
   output logic [WIDTH-1:0] heard_v,
   input  logic             heard_RDY,
   output logic [CNT_W-1:0] write_count,
   output logic [CNT_W-1:0] read_count,
   output logic             proto_err
`ifdef BSCAN_BRIDGE_LOOPBACK_EN
   ,
   input  logic             loopback
`endif
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int PW = AW + 1;

   logic lb;
`ifdef BSCAN_BRIDGE_LOOPBACK_EN
   assign lb = loopback;
`else
   assign lb = 1'b0;
`endif

   logic [PW-1:0]    tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
   logic [PW-1:0]    rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
   logic [WIDTH-1:0] tx_mem_q [DEPTH];
   logic [WIDTH-1:0] tx_mem_d [DEPTH];
   logic [WIDTH-1:0] rx_mem_q [DEPTH];
   logic [WIDTH-1:0] rx_mem_d [DEPTH];
   logic [CNT_W-1:0] write_count_q, write_count_d;
   logic [CNT_W-1:0] read_count_q, read_count_d;
   logic             proto_err_q, proto_err_d;

   logic             tx_full, tx_empty, rx_full, rx_empty;
   logic             tx_push, tx_pop, rx_push, rx_pop;
   logic             tob_fire, lb_fire, frb_fire;
   logic [WIDTH-1:0] tx_head, rx_head, rx_in;

   // FIFO status and channel handshakes; RDY outputs use registered state only
   always_comb begin
      tx_full  = (tx_wr_q[AW] != tx_rd_q[AW]) && (tx_wr_q[AW-1:0] == tx_rd_q[AW-1:0]);
      tx_empty = (tx_wr_q == tx_rd_q);
      rx_full  = (rx_wr_q[AW] != rx_rd_q[AW]) && (rx_wr_q[AW-1:0] == rx_rd_q[AW-1:0]);
      rx_empty = (rx_wr_q == rx_rd_q);
      tx_head  = tx_mem_q[tx_rd_q[AW-1:0]];
      rx_head  = rx_mem_q[rx_rd_q[AW-1:0]];

      say_RDY           = !RST && !tx_full;
      frombscan_enq_RDY = !RST && !rx_full && !lb;
      tobscan_enq_ENA   = !tx_empty && !lb;
      tobscan_enq_v     = tx_empty ? '0 : tx_head;
      heard_ENA         = !rx_empty;
      heard_v           = rx_empty ? '0 : rx_head;

      tob_fire = tobscan_enq_ENA && tobscan_enq_RDY;
      lb_fire  = lb && !tx_empty && !rx_full;
      frb_fire = frombscan_enq_ENA && frombscan_enq_RDY;
      tx_push  = say_ENA && say_RDY;
      tx_pop   = tob_fire || lb_fire;
      // external RX push and loopback move are exclusive: RX RDY is low in loopback
      rx_push  = frb_fire || lb_fire;
      rx_in    = lb_fire ? tx_head : frombscan_enq_v;
      rx_pop   = heard_ENA && heard_RDY;
   end

   // next-state for pointers, storage, counters and the error flag
   always_comb begin
      tx_wr_d       = tx_wr_q;
      tx_rd_d       = tx_rd_q;
      rx_wr_d       = rx_wr_q;
      rx_rd_d       = rx_rd_q;
      tx_mem_d      = tx_mem_q;
      rx_mem_d      = rx_mem_q;
      write_count_d = write_count_q;
      read_count_d  = read_count_q;
      proto_err_d   = proto_err_q;

      if (tx_push) begin
         tx_mem_d[tx_wr_q[AW-1:0]] = say_v;
         tx_wr_d = tx_wr_q + PW'(1);
      end
      if (tx_pop) begin
         tx_rd_d       = tx_rd_q + PW'(1);
         write_count_d = write_count_q + CNT_W'(1);
      end
      if (rx_push) begin
         rx_mem_d[rx_wr_q[AW-1:0]] = rx_in;
         rx_wr_d = rx_wr_q + PW'(1);
      end
      if (rx_pop) begin
         rx_rd_d      = rx_rd_q + PW'(1);
         read_count_d = read_count_q + CNT_W'(1);
      end
      if ((say_ENA && !say_RDY) || (frombscan_enq_ENA && !frombscan_enq_RDY))
         proto_err_d = 1'b1;
   end

   // state registers
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         tx_wr_q       <= '0;
         tx_rd_q       <= '0;
         rx_wr_q       <= '0;
         rx_rd_q       <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            tx_mem_q[i] <= '0;
            rx_mem_q[i] <= '0;
         end
         write_count_q <= '0;
         read_count_q  <= '0;
         proto_err_q   <= 1'b0;
      end else begin
         tx_wr_q       <= tx_wr_d;
         tx_rd_q       <= tx_rd_d;
         rx_wr_q       <= rx_wr_d;
         rx_rd_q       <= rx_rd_d;
         tx_mem_q      <= tx_mem_d;
         rx_mem_q      <= rx_mem_d;
         write_count_q <= write_count_d;
         read_count_q  <= read_count_d;
         proto_err_q   <= proto_err_d;
      end
   end

   assign write_count = write_count_q;
   assign read_count  = read_count_q;
   assign proto_err   = proto_err_q;

endmodule

// File: tb/tb_bscan_bridge_queue.sv
// Scoreboard bench for bscan_bridge_queue: queue-based reference FIFOs,
// checked every cycle at the falling clock edge.
module tb_bscan_bridge_queue;

   localparam int WIDTH = 32;
   localparam int DEPTH = 4;
   localparam int CNT_W = 8;

   logic             CLK = 1'b0;
   logic             RST = 1'b1;
   logic             say_ENA = 1'b0;
   logic [WIDTH-1:0] say_v = '0;
   logic             say_RDY;
   logic             tobscan_enq_ENA;
   logic [WIDTH-1:0] tobscan_enq_v;
   logic             tobscan_enq_RDY = 1'b0;
   logic             frombscan_enq_ENA = 1'b0;
   logic [WIDTH-1:0] frombscan_enq_v = '0;
   logic             frombscan_enq_RDY;
   logic             heard_ENA;
   logic [WIDTH-1:0] heard_v;
   logic             heard_RDY = 1'b0;
   logic [CNT_W-1:0] write_count;
   logic [CNT_W-1:0] read_count;
   logic             proto_err;
   logic             lb = 1'b0;

   bscan_bridge_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .CLK               (CLK),
      .RST               (RST),
      .say_ENA           (say_ENA),
      .say_v             (say_v),
      .say_RDY           (say_RDY),
      .tobscan_enq_ENA   (tobscan_enq_ENA),
      .tobscan_enq_v     (tobscan_enq_v),
      .tobscan_enq_RDY   (tobscan_enq_RDY),
      .frombscan_enq_ENA (frombscan_enq_ENA),
      .frombscan_enq_v   (frombscan_enq_v),
      .frombscan_enq_RDY (frombscan_enq_RDY),
      .heard_ENA         (heard_ENA),
      .heard_v           (heard_v),
      .heard_RDY         (heard_RDY),
      .write_count       (write_count),
      .read_count        (read_count),
      .proto_err         (proto_err)
`ifdef BSCAN_BRIDGE_LOOPBACK_EN
      ,
      .loopback          (lb)
`endif
   );

   always #5 CLK = ~CLK;

   int errors = 0;
   int checks = 0;

   // reference state: FIFO contents as plain queues, counters as integers
   logic [WIDTH-1:0] txq [$];
   logic [WIDTH-1:0] rxq [$];
   int unsigned      m_wc = 0;
   int unsigned      m_rc = 0;
   bit               m_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // monitor: compare outputs against the reference, then advance it
   always @(negedge CLK) begin
      bit e_say_rdy, e_frb_rdy, e_tob_ena, say_x, tob_x, mv_x, frb_x, hrd_x;
      logic [WIDTH-1:0] moved;
      if (RST) begin
         txq.delete();
         rxq.delete();
         m_wc = 0;
         m_rc = 0;
         m_err = 0;
         chk("rst_say_rdy", say_RDY, 0);
         chk("rst_frb_rdy", frombscan_enq_RDY, 0);
         chk("rst_tob_ena", tobscan_enq_ENA, 0);
         chk("rst_heard_ena", heard_ENA, 0);
         chk("rst_wc", write_count, 0);
         chk("rst_rc", read_count, 0);
         chk("rst_err", proto_err, 0);
      end else begin
         e_say_rdy = txq.size() < DEPTH;
         e_frb_rdy = (rxq.size() < DEPTH) && !lb;
         e_tob_ena = (txq.size() > 0) && !lb;
         chk("say_rdy", say_RDY, e_say_rdy);
         chk("frb_rdy", frombscan_enq_RDY, e_frb_rdy);
         chk("tob_ena", tobscan_enq_ENA, e_tob_ena);
         chk("tob_v", tobscan_enq_v, (txq.size() > 0) ? txq[0] : '0);
         chk("heard_ena", heard_ENA, rxq.size() > 0);
         chk("heard_v", heard_v, (rxq.size() > 0) ? rxq[0] : '0);
         chk("write_count", write_count, m_wc % (1 << CNT_W));
         chk("read_count", read_count, m_rc % (1 << CNT_W));
         chk("proto_err", proto_err, m_err);

         say_x = say_ENA && e_say_rdy;
         tob_x = e_tob_ena && tobscan_enq_RDY;
         mv_x  = lb && (txq.size() > 0) && (rxq.size() < DEPTH);
         frb_x = frombscan_enq_ENA && e_frb_rdy;
         hrd_x = (rxq.size() > 0) && heard_RDY;
         if ((say_ENA && !e_say_rdy) || (frombscan_enq_ENA && !e_frb_rdy)) m_err = 1;
         moved = '0;
         if (tob_x || mv_x) begin
            moved = txq.pop_front();
            m_wc++;
         end
         if (say_x) txq.push_back(say_v);
         if (hrd_x) begin
            void'(rxq.pop_front());
            m_rc++;
         end
         if (frb_x) rxq.push_back(frombscan_enq_v);
         if (mv_x)  rxq.push_back(moved);
      end
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_inputs();
      say_ENA = 0;
      frombscan_enq_ENA = 0;
      tobscan_enq_RDY = 0;
      heard_RDY = 0;
   endtask

   // randomized traffic; pct values bias the offer/accept rates
   task automatic random_run(input int n, input int say_pct, input int frb_pct,
                             input int tob_pct, input int hrd_pct, input bit lb_toggle);
      for (int i = 0; i < n; i++) begin
         say_ENA           = ($urandom_range(99) < say_pct);
         say_v             = $urandom;
         frombscan_enq_ENA = ($urandom_range(99) < frb_pct);
         frombscan_enq_v   = $urandom;
         tobscan_enq_RDY   = ($urandom_range(99) < tob_pct);
         heard_RDY         = ($urandom_range(99) < hrd_pct);
`ifdef BSCAN_BRIDGE_LOOPBACK_EN
         if (lb_toggle && ($urandom_range(7) == 0)) lb = ~lb;
`else
         if (lb_toggle) lb = 1'b0;
`endif
         step();
      end
      idle_inputs();
   endtask

   logic [WIDTH-1:0] pattern [4];

   initial begin
      pattern[0] = 32'h11; pattern[1] = 32'h22; pattern[2] = 32'h33; pattern[3] = 32'h44;
      RST = 1;
      repeat (3) step();
      RST = 0;
      step();

      // fill TX with downstream stalled, then overflow by one
      for (int i = 0; i < 4; i++) begin
         say_ENA = 1;
         say_v   = pattern[i];
         step();
      end
      say_v = 32'h55;
      step();
      say_ENA = 0;
      step();
      tobscan_enq_RDY = 1;
      repeat (6) step();
      tobscan_enq_RDY = 0;

      // two-word RX burst with host acceptance toggling
      frombscan_enq_ENA = 1;
      frombscan_enq_v   = 32'hA5;
      step();
      frombscan_enq_v   = 32'h5A;
      step();
      frombscan_enq_ENA = 0;
      for (int i = 0; i < 8; i++) begin
         heard_RDY = i[0];
         step();
      end
      heard_RDY = 0;

      // clean reset, then sustained full-rate traffic to wrap the counters
      RST = 1;
      step();
      RST = 0;
      step();
      random_run(600, 95, 95, 100, 100, 0);
      random_run(1500, 60, 60, 50, 50, 0);

      // reset in the middle of traffic discards in-flight words
      say_ENA = 1; frombscan_enq_ENA = 1; say_v = $urandom; frombscan_enq_v = $urandom;
      step();
      step();
      RST = 1;
      idle_inputs();
      step();
      RST = 0;
      step();
      random_run(800, 40, 40, 70, 70, 0);

`ifdef BSCAN_BRIDGE_LOOPBACK_EN
      RST = 1;
      step();
      RST = 0;
      lb = 1;
      step();
      say_ENA = 1;
      say_v   = 32'hDEADBEEF;
      step();
      say_ENA = 0;
      repeat (3) step();
      heard_RDY = 1;
      step();
      heard_RDY = 0;
      random_run(1500, 50, 30, 60, 60, 1);
      lb = 0;
`endif

      step();
      @(negedge CLK);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bscan_bridge_queue.md
# bscan_bridge_queue

Parametrised host-to-JTAG bridge: buffers host `say` words in a DEPTH-entry transmit FIFO and drains them into the BSCAN `toBscan` pipe. Returns words arriving on the BSCAN `fromBscan` pipe to the host through a DEPTH-entry receive FIFO on the `heard` indication. Keeps wrapping transfer counters and a sticky protocol-error flag. Sits between the request/indication portal and the `Bscan` instance, replacing the single-register, unbuffered bridge of the previous generation.

## Interface
Parameters:
- WIDTH, 32, data word width (1..64)
- DEPTH, 4, entries per FIFO; power of two, >= 2
- CNT_W, 8, width of transfer counters

Ports:
- CLK  in  1  clock; all state on rising edge
- RST  in  1  reset; asynchronous, active-high
- say_ENA  in  1  host offers word
- say_v  in  WIDTH  host word
- say_RDY  out  1  TX FIFO not full
- tobscan_enq_ENA  out  1  word valid toward BSCAN
- tobscan_enq_v  out  WIDTH  TX FIFO head
- tobscan_enq_RDY  in  1  BSCAN accepts
- frombscan_enq_ENA  in  1  BSCAN offers word
- frombscan_enq_v  in  WIDTH  BSCAN word
- frombscan_enq_RDY  out  1  RX FIFO not full
- heard_ENA  out  1  word valid toward host
- heard_v  out  WIDTH  RX FIFO head
- heard_RDY  in  1  host accepts
- write_count  out  CNT_W  words delivered to BSCAN
- read_count  out  CNT_W  words delivered to host
- proto_err  out  1  sticky: ENA seen while RDY low
- loopback  in  1  route TX to RX internally (present only with BSCAN_BRIDGE_LOOPBACK_EN)

## Operation
- Transfer occurs on a channel in a cycle iff ENA && RDY on that channel.
- TX FIFO: push on say transfer; pop on tobscan transfer. tobscan_enq_ENA = !tx_empty; tobscan_enq_v = head; tobscan_enq_v is 0 when empty.
- RX FIFO: push on frombscan transfer; pop on heard transfer. heard_ENA = !rx_empty; heard_v = head; heard_v is 0 when empty.
- Each FIFO uses read/write pointers of log2(DEPTH)+1 bits. Full = MSBs differ and low bits equal. Empty = pointers equal. Pointers wrap modulo 2*DEPTH.
- No bypass: an empty FIFO never forwards the same-cycle input.
- Full FIFO: RDY is low and no push happens, even when a pop occurs in the same cycle.
- Simultaneous push and pop on a non-full, non-empty FIFO: occupancy is unchanged and order is preserved.
- write_count += 1 per tobscan transfer. read_count += 1 per heard transfer. Both wrap modulo 2^CNT_W.
- proto_err is set when say_ENA && !say_RDY, or when frombscan_enq_ENA && !frombscan_enq_RDY. The offending word is dropped. proto_err is cleared only by reset.

## Timing
- Reset: all pointers, counters and proto_err are 0. All outputs are 0, including say_RDY and frombscan_enq_RDY, while RST is high. Deasserting RST mid-operation resumes with empty FIFOs; any in-flight words are discarded.
- say_RDY rises in the first cycle after RST falls.
- Latency from say transfer at cycle N to tobscan_enq_ENA is cycle N+1 (FIFO previously empty). The same applies from frombscan to heard.
- RDY outputs depend only on registered state, never combinationally on ENA inputs.
- Throughput: one word per cycle per direction when the downstream RDY is held high.

## Configuration
- BSCAN_BRIDGE_LOOPBACK_EN defined: `loopback` port exists.
  - When loopback=1: tobscan_enq_ENA=0 and frombscan_enq_RDY=0. A TX pop occurs iff !tx_empty && !rx_full, pushing the TX head into the RX FIFO. write_count counts these moves.
  - loopback is evaluated every cycle. Toggling it between words loses nothing.
- Macro undefined: port absent; behaviour is identical to loopback=0.

## Test plan
- Reset then idle: say_RDY=1 at cycle 1; tobscan_enq_ENA=0; counters=0; proto_err=0.
- DEPTH=4, tobscan_enq_RDY=0, push 0x11,0x22,0x33,0x44 -> say_RDY=0 after the 4th push. Raise RDY -> tobscan delivers 0x11..0x44 in order on 4 consecutive cycles; write_count=4.
- Push a 5th word while full -> word dropped, proto_err=1, FIFO contents unchanged.
- frombscan burst of 0xA5, 0x5A with heard_RDY toggling 0/1 -> heard delivers 0xA5 then 0x5A, no duplicates; read_count=2.
- CNT_W=8, 257 TX transfers -> write_count=1.
- BSCAN_BRIDGE_LOOPBACK_EN with loopback=1: push 0xDEADBEEF -> heard_v=0xDEADBEEF at cycle N+2; tobscan_enq_ENA stays 0; write_count=1; read_count=1 after heard transfer.
